// File: rtl/key_commit_ctrl.sv
// key_commit_ctrl: edit/commit sequencer for the display parameters A and B.
// Step pulses edit shadow copies. Enter arms a commit, and the next frame start
// moves the shadows into the live registers, so a change never lands mid-frame.
// Optional macro KEY_COMMIT_TIMEOUT_EN: an edit left alone for TIMEOUT_FRAMES
// frames is discarded.
module key_commit_ctrl #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned STEP           = 1,
  parameter int unsigned INIT_A         = 0,
  parameter int unsigned INIT_B         = 0,
  parameter int unsigned WRAP           = 1,
  parameter int unsigned TIMEOUT_FRAMES = 300
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc_a,
  input  logic             i_dec_a,
  input  logic             i_inc_b,
  input  logic             i_dec_b,
  input  logic             i_enter,
  input  logic             i_frame_start,
  output logic [WIDTH-1:0] o_reg_A,
  output logic [WIDTH-1:0] o_reg_B,
  output logic [WIDTH-1:0] o_shadow_A,
  output logic [WIDTH-1:0] o_shadow_B,
  output logic             o_pending,
  output logic             o_commit,
  output logic             o_revert
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] RST_A  = WIDTH'(INIT_A);
  localparam logic [WIDTH-1:0] RST_B  = WIDTH'(INIT_B);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_ARMED, S_COMMIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic             step_any;

  // One step of the configured arithmetic; opposing pulses cancel.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] cur,
                                                input logic inc, input logic dec);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + STEP_X;
    if (inc && !dec) begin
      if (WRAP != 0 || sum <= MAX_X) return sum[WIDTH-1:0];
      return '1;
    end
    if (dec && !inc) begin
      if (WRAP != 0 || {1'b0, cur} >= STEP_X) return cur - WIDTH'(STEP);
      return '0;
    end
    return cur;
  endfunction

  // Candidate shadow values and whether any channel actually stepped.
  always_comb begin
    next_a   = step_val(o_shadow_A, i_inc_a, i_dec_a);
    next_b   = step_val(o_shadow_B, i_inc_b, i_dec_b);
    step_any = (i_inc_a ^ i_dec_a) | (i_inc_b ^ i_dec_b);
  end

`ifdef KEY_COMMIT_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  logic [CNT_W-1:0] frame_cnt;
`endif

  // Sequencer: state, shadows, live registers and output pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_shadow_A <= RST_A;
      o_shadow_B <= RST_B;
      o_reg_A    <= RST_A;
      o_reg_B    <= RST_B;
      o_pending  <= 1'b0;
      o_commit   <= 1'b0;
      o_revert   <= 1'b0;
`ifdef KEY_COMMIT_TIMEOUT_EN
      frame_cnt  <= '0;
`endif
    end else begin
      o_commit <= 1'b0;
      o_revert <= 1'b0;
      case (state)
        S_IDLE: begin
          o_pending <= 1'b0;
          if (step_any) begin
            o_shadow_A <= next_a;
            o_shadow_B <= next_b;
            o_pending  <= 1'b1;
            state      <= S_EDIT;
          end
        end
        S_EDIT: begin
          o_shadow_A <= next_a;
          o_shadow_B <= next_b;
          o_pending  <= 1'b1;
          if (i_enter) begin
            state <= S_ARMED;
`ifdef KEY_COMMIT_TIMEOUT_EN
            frame_cnt <= '0;
          end else if (step_any) begin
            frame_cnt <= '0;
          end else if (i_frame_start) begin
            if (frame_cnt == CNT_LAST) begin
              // Idle too long: drop the edit and fall back to the live values.
              o_shadow_A <= o_reg_A;
              o_shadow_B <= o_reg_B;
              o_revert   <= 1'b1;
              o_pending  <= 1'b0;
              frame_cnt  <= '0;
              state      <= S_IDLE;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
`endif
          end
        end
        S_ARMED: begin
          o_pending <= 1'b1;
          if (i_frame_start) state <= S_COMMIT;
        end
        S_COMMIT: begin
          // Pending stays high until the live registers actually change.
          o_reg_A   <= o_shadow_A;
          o_reg_B   <= o_shadow_B;
          o_commit  <= 1'b1;
          o_pending <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
